// File: rtl/alu_op_sequencer_if.sv
// Host/ALU-facing bus of the ALU opcode sequencer.
// The sequencer connects through the slave modport; the host side (which
// also supplies the ALU result) connects through the master modport.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int OP_W  = 3
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OP_W-1:0]  alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             busy;
  logic             done;
  logic             res_valid;
  logic [OP_W-1:0]  res_op;
  logic [WIDTH-1:0] res_data;
  logic [OP_W-1:0]  rd_addr;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output start, a_in, b_in, alu_result, rd_addr,
    input  alu_a, alu_b, alu_op, busy, done, res_valid, res_op, res_data, rd_data
  );

  modport slave (
    input  start, a_in, b_in, alu_result, rd_addr,
    output alu_a, alu_b, alu_op, busy, done, res_valid, res_op, res_data, rd_data
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// ALU opcode sequencer: latches one operand pair on start, presents it to the
// combinational ALU with opcodes 0..NUM_OPS-1 (each held DWELL cycles),
// streams each captured result out and stores it in a per-opcode bank.
module alu_op_sequencer #(
  parameter int WIDTH   = 4,
  parameter int OP_W    = 3,
  parameter int NUM_OPS = 8,
  parameter int DWELL   = 4
) (
  input logic clk,
  input logic rst,
  alu_op_sequencer_if.slave bus
);
  localparam int CW   = $clog2(DWELL + 1);
  localparam int BANK = 2 ** OP_W;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] alu_a, alu_b, res_data;
  logic [OP_W-1:0]  alu_op, res_op;
  logic             busy, done, res_valid;
  logic [WIDTH-1:0] bank [BANK];
  logic             accept, capture, last;

  // Next state plus per-cycle control strobes (accept / capture / last capture).
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    capture = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(DWELL - 1)) begin
          capture = 1'b1;
          if (alu_op == OP_W'(NUM_OPS - 1)) begin
            last    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Operand/opcode drive, dwell counter and result streaming registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      res_op    <= '0;
      res_data  <= '0;
    end else begin
      res_valid <= capture;
      done      <= last;
      if (accept) begin
        alu_a  <= bus.a_in;
        alu_b  <= bus.b_in;
        alu_op <= '0;
        cnt    <= '0;
        busy   <= 1'b1;
      end else if (state == RUN) begin
        if (capture) begin
          res_data <= bus.alu_result;
          res_op   <= alu_op;
          if (last) begin
            busy <= 1'b0;
          end else begin
            alu_op <= alu_op + 1'b1;
            cnt    <= '0;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Per-opcode result bank; entries persist until overwritten or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BANK; i++) bank[i] <= '0;
    end else if (capture) begin
      bank[alu_op] <= bus.alu_result;
    end
  end

  assign bus.alu_a     = alu_a;
  assign bus.alu_b     = alu_b;
  assign bus.alu_op    = alu_op;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.res_valid = res_valid;
  assign bus.res_op    = res_op;
  assign bus.res_data  = res_data;
  assign bus.rd_data   = bank[bus.rd_addr];
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: three instances cover DWELL=4/NUM_OPS=8,
// DWELL=1/NUM_OPS=8 and DWELL=2/NUM_OPS=3. The ALU is modelled in the bench.
module tb_alu_op_sequencer;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_op_sequencer_if #(.WIDTH(4), .OP_W(3)) ifa ();
  alu_op_sequencer_if #(.WIDTH(4), .OP_W(3)) ifb ();
  alu_op_sequencer_if #(.WIDTH(4), .OP_W(3)) ifc ();

  alu_op_sequencer #(.WIDTH(4), .OP_W(3), .NUM_OPS(8), .DWELL(4)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa));
  alu_op_sequencer #(.WIDTH(4), .OP_W(3), .NUM_OPS(8), .DWELL(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb));
  alu_op_sequencer #(.WIDTH(4), .OP_W(3), .NUM_OPS(3), .DWELL(2)) dut_c (
    .clk(clk), .rst(rst), .bus(ifc));

  // Bench ALU: add, sub, and, or, xor, not-a, shl-a, shr-a.
  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  assign ifa.alu_result = alu_f(ifa.alu_a, ifa.alu_b, ifa.alu_op);
  assign ifb.alu_result = alu_f(ifb.alu_a, ifb.alu_b, ifb.alu_op);
  assign ifc.alu_result = alu_f(ifc.alu_a, ifc.alu_b, ifc.alu_op);

  // Hand-computed results per opcode.
  logic [3:0] exp91 [8] = '{4'hA, 4'h8, 4'h1, 4'h9, 4'h8, 4'h6, 4'h2, 4'h4};
  logic [3:0] exp75 [8] = '{4'hC, 4'h2, 4'h5, 4'h7, 4'h2, 4'h8, 4'hE, 4'h3};
  logic [3:0] exp32 [8] = '{4'h5, 4'h1, 4'h2, 4'h3, 4'h1, 4'hC, 4'h6, 4'h1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at the falling edge after start-accept edge T of dut_a; follows
  // the run to T+32. Operand inputs are changed to na/nb mid-run.
  task automatic watch_a(input logic [3:0] ea, input logic [3:0] eb,
                         input logic [3:0] exp [8],
                         input logic [3:0] na, input logic [3:0] nb);
    chk("a busy@T", ifa.busy, 1);
    chk("a alu_a@T", ifa.alu_a, ea);
    chk("a alu_b@T", ifa.alu_b, eb);
    chk("a alu_op@T", ifa.alu_op, 0);
    chk("a rv@T", ifa.res_valid, 0);
    for (int n = 1; n <= 32; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 5) begin
        ifa.a_in = na;
        ifa.b_in = nb;
      end
      chk($sformatf("a rv n=%0d", n), ifa.res_valid, (n % 4) == 0);
      chk($sformatf("a done n=%0d", n), ifa.done, n == 32);
      chk($sformatf("a busy n=%0d", n), ifa.busy, n < 32);
      chk($sformatf("a alu_op n=%0d", n), ifa.alu_op, (n < 32) ? n / 4 : 7);
      if ((n % 4) == 0) begin
        chk($sformatf("a res_op n=%0d", n), ifa.res_op, n / 4 - 1);
        chk($sformatf("a res_data n=%0d", n), ifa.res_data, exp[n / 4 - 1]);
      end
    end
  endtask

  initial begin
    logic quiet;
    logic [3:0] ra, rb;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ifa.start = 1'b0; ifa.a_in = '0; ifa.b_in = '0; ifa.rd_addr = '0;
    ifb.start = 1'b0; ifb.a_in = '0; ifb.b_in = '0; ifb.rd_addr = '0;
    ifc.start = 1'b0; ifc.a_in = '0; ifc.b_in = '0; ifc.rd_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst busy", ifa.busy, 0);
    chk("rst done", ifa.done, 0);
    chk("rst rv", ifa.res_valid, 0);
    chk("rst alu_a", ifa.alu_a, 0);
    chk("rst alu_op", ifa.alu_op, 0);
    chk("rst res_data", ifa.res_data, 0);
    chk("rst rd_data", ifa.rd_data, 0);

    // Single run with a=9, b=1
    @(negedge clk);
    ifa.a_in = 4'd9; ifa.b_in = 4'd1; ifa.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifa.start = 1'b0;
    watch_a(4'd9, 4'd1, exp91, 4'd9, 4'd1);
    repeat (3) @(negedge clk);
    chk("idle busy", ifa.busy, 0);
    chk("idle rv", ifa.res_valid, 0);
    chk("idle alu_a hold", ifa.alu_a, 9);
    chk("idle alu_op hold", ifa.alu_op, 7);

    // Bank readback, twice with idle cycles between
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 8; i++) begin
        ifa.rd_addr = 3'(i);
        #1;
        chk($sformatf("bank p=%0d i=%0d", p, i), ifa.rd_data, exp91[i]);
      end
      repeat (5) @(negedge clk);
    end

    // start held high through a run; operands change mid-run
    ifa.a_in = 4'd7; ifa.b_in = 4'd5; ifa.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    watch_a(4'd7, 4'd5, exp75, 4'd3, 4'd2);
    @(posedge clk);
    @(negedge clk);
    ifa.start = 1'b0;
    watch_a(4'd3, 4'd2, exp32, 4'd3, 4'd2);

    // Reset mid-run at T+10
    @(negedge clk);
    ifa.a_in = 4'd9; ifa.b_in = 4'd1; ifa.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifa.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("pre-rst busy", ifa.busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid-rst busy", ifa.busy, 0);
    chk("mid-rst done", ifa.done, 0);
    chk("mid-rst rv", ifa.res_valid, 0);
    chk("mid-rst alu_a", ifa.alu_a, 0);
    chk("mid-rst alu_b", ifa.alu_b, 0);
    chk("mid-rst alu_op", ifa.alu_op, 0);
    chk("mid-rst res_op", ifa.res_op, 0);
    chk("mid-rst res_data", ifa.res_data, 0);
    for (int i = 0; i < 8; i++) begin
      ifa.rd_addr = 3'(i);
      #1;
      chk($sformatf("mid-rst bank i=%0d", i), ifa.rd_data, 0);
    end
    quiet = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ifa.busy || ifa.done || ifa.res_valid) quiet = 1'b0;
    end
    chk("post-rst quiet", quiet, 1);

    // DWELL=1: capture every cycle
    @(negedge clk);
    ifb.a_in = 4'd9; ifb.b_in = 4'd1; ifb.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifb.start = 1'b0;
    chk("b busy@T", ifb.busy, 1);
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b rv n=%0d", n), ifb.res_valid, n <= 8);
      chk($sformatf("b done n=%0d", n), ifb.done, n == 8);
      chk($sformatf("b busy n=%0d", n), ifb.busy, n < 8);
      if (n <= 8) begin
        chk($sformatf("b res_op n=%0d", n), ifb.res_op, n - 1);
        chk($sformatf("b res_data n=%0d", n), ifb.res_data, exp91[n - 1]);
      end
    end

    // NUM_OPS=3, DWELL=2: two runs, second overwrites bank[0..2]
    for (int r = 0; r < 2; r++) begin
      ra = (r == 0) ? 4'd9 : 4'd7;
      rb = (r == 0) ? 4'd1 : 4'd5;
      @(negedge clk);
      ifc.a_in = ra; ifc.b_in = rb; ifc.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifc.start = 1'b0;
      chk($sformatf("c r=%0d busy@T", r), ifc.busy, 1);
      for (int n = 1; n <= 7; n++) begin
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("c r=%0d rv n=%0d", r, n), ifc.res_valid, (n % 2 == 0) && (n <= 6));
        chk($sformatf("c r=%0d done n=%0d", r, n), ifc.done, n == 6);
        chk($sformatf("c r=%0d alu_op n=%0d", r, n), ifc.alu_op, (n < 6) ? n / 2 : 2);
        if ((n % 2 == 0) && (n <= 6)) begin
          chk($sformatf("c r=%0d res_op n=%0d", r, n), ifc.res_op, n / 2 - 1);
          chk($sformatf("c r=%0d res_data n=%0d", r, n), ifc.res_data,
              (r == 0) ? exp91[n / 2 - 1] : exp75[n / 2 - 1]);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      ifc.rd_addr = 3'(i);
      #1;
      chk($sformatf("c bank i=%0d", i), ifc.rd_data, (i < 3) ? exp75[i] : 4'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
